// File: rtl/mux_n_to_1_reg.sv
// N-to-1 registered multiplexer with valid/ready handshaking.
// Fixed mode grants the channel named by sel. Round-robin mode grants the first
// valid channel after the last one served. The selected word sits in a single
// output register that drains whenever downstream is ready.
module mux_n_to_1_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    // Pointer reset to the last channel, so channel 0 is searched first.
    localparam logic [SELW-1:0] PTR_RESET = SELW'(N - 1);

    logic            load_en;
    logic            grant_any;
    logic            transfer;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] ptr;
    logic [WIDTH-1:0] grant_data;

    assign load_en  = !out_valid || out_ready;
    assign transfer = load_en && grant_any && !reset;

    // Pick the channel to serve: sel in fixed mode, next valid after ptr in round-robin.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!grant_any && in_valid[(int'(ptr) + k) % N]) begin
                    grant_any = 1'b1;
                    grant_idx = SELW'((int'(ptr) + k) % N);
                end
            end
        end
    end

    // Route the granted channel's word toward the output register.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept only the granted channel, and only when the output register can load.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = transfer && (grant_idx == SELW'(i));
        end
    end

    // Output register and round-robin pointer; a held entry is never disturbed.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= PTR_RESET;
        end else if (load_en) begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                if (mode) begin
                    ptr <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
